// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave bank of PPC-writable shadow/output registers for user fabric.
// Outputs load immediately (auto) or atomically on a CTRL commit.
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_NUM_REGS   = 4,
  parameter logic [31:0] C_RESET_VAL  = 32'h0000_0000,
  parameter              C_FAMILY     = "virtex6"
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst,
  input  logic [0:31]             OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:31]             OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:31]             Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  output logic [C_NUM_REGS*32-1:0] user_data_out,
  output logic [C_NUM_REGS-1:0]   user_update
);

  localparam logic [5:0] CTRL_IDX = 6'(C_NUM_REGS);

  typedef enum logic {S_IDLE, S_ACK} state_t;

  state_t state;

  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [5:0]  idx;
  logic        hit;
  logic        accept;
  logic        wr;
  logic        ctrl_wr;
  logic        commit;
  logic [31:0] rdata;
  logic [31:0] dbus_q;

  logic [31:0]           shadow [C_NUM_REGS];
  logic [31:0]           out_q  [C_NUM_REGS];
  logic [C_NUM_REGS-1:0] pending;
  logic [C_NUM_REGS-1:0] load;
  logic                  auto_q;
  logic [15:0]           cnt;

  logic unused_ok;

  // [0:n] bus vectors land MSB-first in [n:0], giving bit j -> 31-j
  assign addr  = OPB_ABus;
  assign wdata = OPB_DBus;
  assign be    = OPB_BE;
  assign idx   = addr[7:2];

  assign hit = OPB_select &&
    ((addr - C_BASEADDR) <= (C_HIGHADDR - C_BASEADDR));
  assign accept  = hit && (state == S_IDLE);
  assign wr      = accept && !OPB_RNW;
  assign ctrl_wr = wr && (idx == CTRL_IDX) && be[0];
  assign commit  = ctrl_wr && wdata[0];

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] d,
    input logic [3:0]  b
  );
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++)
      if (b[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  always_comb begin
    rdata = '0;
    if (idx == CTRL_IDX)
      rdata = {cnt, 14'b0, auto_q, |pending};
    for (int i = 0; i < C_NUM_REGS; i++)
      if (idx == 6'(i)) rdata = shadow[i];
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
    if (!OPB_Rst) begin
      state       <= S_IDLE;
      dbus_q      <= '0;
      pending     <= '0;
      load        <= '0;
      user_update <= '0;
      auto_q      <= 1'b1;
      cnt         <= '0;
      for (int i = 0; i < C_NUM_REGS; i++) begin
        shadow[i] <= C_RESET_VAL;
        out_q[i]  <= C_RESET_VAL;
      end
    end else begin
      state       <= accept ? S_ACK : S_IDLE;
      dbus_q      <= (accept && OPB_RNW) ? rdata : '0;
      load        <= '0;
      user_update <= load;
      for (int i = 0; i < C_NUM_REGS; i++)
        if (load[i]) out_q[i] <= shadow[i];
      if (commit) begin
        load    <= pending;
        pending <= '0;
        cnt     <= cnt + 16'd1;
      end
      if (ctrl_wr) auto_q <= wdata[1];
      for (int i = 0; i < C_NUM_REGS; i++) begin
        if (wr && idx == 6'(i)) begin
          shadow[i] <= merge(shadow[i], wdata, be);
          if (auto_q) load[i]    <= 1'b1;
          else        pending[i] <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
    assign user_data_out[32*g +: 32] = out_q[g];
  end

  assign Sl_DBus    = dbus_q;
  assign Sl_xferAck = (state == S_ACK);
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  assign unused_ok = ^{OPB_seqAddr, C_OPB_AWIDTH == 32,
                       C_OPB_DWIDTH == 32, ^C_FAMILY};

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Randomized self-checking bench for opb_register_bank_ppc2simulink
// against a transaction-level model of the register bank.
module tb_opb_register_bank_ppc2simulink;

  localparam int N = 4;
  localparam logic [31:0] BASE = 32'h8000_0100;
  localparam logic [31:0] HIGH = 32'h8000_01FF;
  localparam logic [31:0] RVAL = 32'hC0DE_0001;

  logic clk = 1'b0;
  logic rst_n;
  logic [0:31] abus;
  logic [0:3]  be;
  logic [0:31] dbus;
  logic rnw, sel, seq;
  logic [0:31] sl_dbus;
  logic ack, err, retry, tout;
  logic [N*32-1:0] udo;
  logic [N-1:0] upd;

  int errs = 0;
  int checks = 0;

  logic [31:0] m_sh  [N];
  logic [31:0] m_out [N];
  logic [N-1:0] m_pend;
  bit m_auto;
  logic [15:0] m_cnt;

  opb_register_bank_ppc2simulink #(
    .C_BASEADDR (BASE),
    .C_HIGHADDR (HIGH),
    .C_NUM_REGS (N),
    .C_RESET_VAL(RVAL)
  ) dut (
    .OPB_Clk      (clk),
    .OPB_Rst      (rst_n),
    .OPB_ABus     (abus),
    .OPB_BE       (be),
    .OPB_DBus     (dbus),
    .OPB_RNW      (rnw),
    .OPB_select   (sel),
    .OPB_seqAddr  (seq),
    .Sl_DBus      (sl_dbus),
    .Sl_xferAck   (ack),
    .Sl_errAck    (err),
    .Sl_retry     (retry),
    .Sl_toutSup   (tout),
    .user_data_out(udo),
    .user_update  (upd)
  );

  always #5 clk = ~clk;

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      m_sh[i]  = RVAL;
      m_out[i] = RVAL;
    end
    m_pend = '0;
    m_auto = 1'b1;
    m_cnt  = '0;
  endfunction

  function automatic logic [31:0] m_ctrl();
    return {m_cnt, 14'b0, m_auto, |m_pend};
  endfunction

  function automatic logic [31:0] m_read(int i);
    if (i < N) return m_sh[i];
    if (i == N) return m_ctrl();
    return 32'h0;
  endfunction

  // returns the set of outputs this write is expected to load
  function automatic logic [N-1:0] m_write(
    int i, logic [31:0] d, logic [0:3] b
  );
    logic [N-1:0] ld = '0;
    if (i < N) begin
      for (int k = 0; k < 4; k++)
        if (b[k]) m_sh[i][31-8*k -: 8] = d[31-8*k -: 8];
      if (m_auto) ld[i] = 1'b1;
      else m_pend[i] = 1'b1;
    end else if (i == N && b[3]) begin
      if (d[0]) begin
        ld = m_pend;
        m_pend = '0;
        m_cnt = m_cnt + 16'd1;
      end
      m_auto = d[1];
    end
    for (int j = 0; j < N; j++)
      if (ld[j]) m_out[j] = m_sh[j];
    return ld;
  endfunction

  task automatic xfer(
    input bit r, input logic [31:0] a,
    input logic [31:0] d, input logic [0:3] b,
    output logic [31:0] rd, output int lat
  );
    @(negedge clk);
    abus = a; dbus = d; be = b; rnw = r; sel = 1'b1;
    @(posedge clk);
    #1 sel = 1'b0;
    lat = -1;
    rd = '0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (ack) begin
        lat = n;
        rd = sl_dbus;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    int lat;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (udo[32*i +: 32] !== RVAL) begin
        errs++;
        $display("FAIL reset_out[%0d] got=%h exp=%h",
                 i, udo[32*i +: 32], RVAL);
      end
    end
    checks++;
    if ({ack, err, retry, tout, upd, sl_dbus} !== '0) begin
      errs++;
      $display("FAIL reset_outs got ack=%b upd=%b dbus=%h exp=0",
               ack, upd, sl_dbus);
    end
    xfer(1, BASE + 32'(N*4), 0, 4'b1111, rd, lat);
    checks++;
    if (lat !== 0 || rd !== 32'h2) begin
      errs++;
      $display("FAIL reset_ctrl got=%h lat=%0d exp=%h", rd, lat, 32'h2);
    end
  endtask

  task automatic test_auto_write();
    logic [31:0] rd;
    logic [N-1:0] ld;
    int lat;
    ld = m_write(2, 32'hDEAD_BEEF, 4'b1111);
    xfer(0, BASE + 32'd8, 32'hDEAD_BEEF, 4'b1111, rd, lat);
    checks++;
    if (lat !== 0 || rd !== 0) begin
      errs++;
      $display("FAIL auto_ack got lat=%0d dbus=%h exp lat=0 dbus=0",
               lat, rd);
    end
    @(negedge clk);
    checks++;
    if (upd !== ld || udo[64 +: 32] !== m_out[2]) begin
      errs++;
      $display("FAIL auto_load got upd=%b out=%h exp upd=%b out=%h",
               upd, udo[64 +: 32], ld, m_out[2]);
    end
    @(negedge clk);
    checks++;
    if (upd !== '0) begin
      errs++;
      $display("FAIL auto_pulse_width got upd=%b exp=0", upd);
    end
    xfer(1, BASE + 32'd8, 0, 4'b1111, rd, lat);
    checks++;
    if (lat !== 0 || rd !== 32'hDEAD_BEEF) begin
      errs++;
      $display("FAIL auto_readback got=%h exp=%h", rd, 32'hDEAD_BEEF);
    end
    @(negedge clk);
    checks++;
    if (sl_dbus !== 0) begin
      errs++;
      $display("FAIL dbus_after_ack got=%h exp=0", sl_dbus);
    end
  endtask

  task automatic test_byte_enable();
    logic [31:0] rd;
    logic [N-1:0] ld;
    int lat;
    ld = m_write(1, 32'hFFFF_FFFF, 4'b1111);
    xfer(0, BASE + 32'd4, 32'hFFFF_FFFF, 4'b1111, rd, lat);
    ld = m_write(1, 32'h1122_3344, 4'b0101);
    xfer(0, BASE + 32'd4, 32'h1122_3344, 4'b0101, rd, lat);
    @(negedge clk);
    checks++;
    if (upd !== ld || udo[32 +: 32] !== 32'hFF22_FF44) begin
      errs++;
      $display("FAIL be_out got upd=%b out=%h exp upd=%b out=%h",
               upd, udo[32 +: 32], ld, 32'hFF22_FF44);
    end
    xfer(1, BASE + 32'd4, 0, 4'b1111, rd, lat);
    checks++;
    if (rd !== m_sh[1]) begin
      errs++;
      $display("FAIL be_shadow got=%h exp=%h", rd, m_sh[1]);
    end
  endtask

  task automatic test_random_auto();
    logic [31:0] rd, d;
    logic [0:3] b;
    logic [N-1:0] ld;
    int lat, i;
    for (int t = 0; t < 24; t++) begin
      i = $urandom_range(0, N);
      d = $urandom;
      b = 4'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        xfer(1, BASE + 32'(i*4), 0, 4'b1111, rd, lat);
        checks++;
        if (lat !== 0 || rd !== m_read(i)) begin
          errs++;
          $display("FAIL rand_read[%0d] got=%h lat=%0d exp=%h",
                   i, rd, lat, m_read(i));
        end
      end else if (i < N) begin
        ld = m_write(i, d, b);
        xfer(0, BASE + 32'(i*4), d, b, rd, lat);
        @(negedge clk);
        checks++;
        if (lat !== 0 || upd !== ld || udo[32*i +: 32] !== m_out[i]) begin
          errs++;
          $display("FAIL rand_write[%0d] got upd=%b out=%h exp %b %h",
                   i, upd, udo[32*i +: 32], ld, m_out[i]);
        end
      end
    end
  endtask

  task automatic test_manual();
    logic [31:0] rd;
    logic [N-1:0] ld;
    int lat;
    ld = m_write(N, 32'h0, 4'b1110);
    xfer(0, BASE + 32'(N*4), 32'h0, 4'b1110, rd, lat);
    xfer(1, BASE + 32'(N*4), 0, 4'b1111, rd, lat);
    checks++;
    if (rd !== m_ctrl()) begin
      errs++;
      $display("FAIL ctrl_be_gate got=%h exp=%h", rd, m_ctrl());
    end
    ld = m_write(N, 32'h0, 4'b1111);
    xfer(0, BASE + 32'(N*4), 32'h0, 4'b1111, rd, lat);
    ld = m_write(0, 32'hA, 4'b1111);
    xfer(0, BASE, 32'hA, 4'b1111, rd, lat);
    ld = m_write(3, 32'hB, 4'b1111);
    xfer(0, BASE + 32'd12, 32'hB, 4'b1111, rd, lat);
    @(negedge clk);
    checks++;
    if (upd !== '0 || udo[0 +: 32] !== m_out[0] ||
        udo[96 +: 32] !== m_out[3]) begin
      errs++;
      $display("FAIL manual_hold got upd=%b o0=%h o3=%h exp %h %h",
               upd, udo[0 +: 32], udo[96 +: 32], m_out[0], m_out[3]);
    end
    xfer(1, BASE + 32'(N*4), 0, 4'b1111, rd, lat);
    checks++;
    if (rd !== 32'h0000_0001) begin
      errs++;
      $display("FAIL manual_pending got=%h exp=%h", rd, 32'h1);
    end
    ld = m_write(N, 32'h1, 4'b1111);
    xfer(0, BASE + 32'(N*4), 32'h1, 4'b1111, rd, lat);
    @(negedge clk);
    checks++;
    if (upd !== ld || udo[0 +: 32] !== 32'hA ||
        udo[96 +: 32] !== 32'hB) begin
      errs++;
      $display("FAIL commit got upd=%b o0=%h o3=%h exp %b a b",
               upd, udo[0 +: 32], udo[96 +: 32], ld);
    end
    xfer(1, BASE + 32'(N*4), 0, 4'b1111, rd, lat);
    checks++;
    if (rd !== 32'h0001_0000) begin
      errs++;
      $display("FAIL commit_ctrl got=%h exp=%h", rd, 32'h0001_0000);
    end
    ld = m_write(N, 32'h1, 4'b1111);
    xfer(0, BASE + 32'(N*4), 32'h1, 4'b1111, rd, lat);
    @(negedge clk);
    ld = m_write(N, 32'h2, 4'b1111);
    xfer(0, BASE + 32'(N*4), 32'h2, 4'b1111, rd, lat);
    xfer(1, BASE + 32'(N*4), 0, 4'b1111, rd, lat);
    checks++;
    if (rd !== m_ctrl()) begin
      errs++;
      $display("FAIL empty_commit got=%h exp=%h", rd, m_ctrl());
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd;
    int lat;
    xfer(0, BASE + 32'((N+1)*4), 32'hFFFF_FFFF, 4'b1111, rd, lat);
    @(negedge clk);
    checks++;
    if (lat !== 0 || upd !== '0) begin
      errs++;
      $display("FAIL oor_write got lat=%0d upd=%b exp 0 0", lat, upd);
    end
    xfer(1, BASE + 32'((N+1)*4), 0, 4'b1111, rd, lat);
    checks++;
    if (lat !== 0 || rd !== 0) begin
      errs++;
      $display("FAIL oor_read got=%h lat=%0d exp=0", rd, lat);
    end
    for (int i = 0; i <= N; i++) begin
      xfer(1, BASE + 32'(i*4), 0, 4'b1111, rd, lat);
      checks++;
      if (rd !== m_read(i)) begin
        errs++;
        $display("FAIL oor_state[%0d] got=%h exp=%h", i, rd, m_read(i));
      end
    end
    xfer(1, HIGH + 32'd1, 0, 4'b1111, rd, lat);
    checks++;
    if (lat !== -1) begin
      errs++;
      $display("FAIL miss_high got lat=%0d exp=-1", lat);
    end
    xfer(1, BASE - 32'd4, 0, 4'b1111, rd, lat);
    checks++;
    if (lat !== -1) begin
      errs++;
      $display("FAIL miss_low got lat=%0d exp=-1", lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [0:3] pat;
    @(negedge clk);
    abus = BASE; rnw = 1'b1; be = 4'b1111; sel = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      pat[n] = ack;
    end
    sel = 1'b0;
    @(negedge clk);
    checks++;
    if (pat !== 4'b1010) begin
      errs++;
      $display("FAIL held_select got=%b exp=%b", pat, 4'b1010);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int lat;
    @(negedge clk);
    abus = BASE + 32'd4; dbus = 32'h1234_5678;
    be = 4'b1111; rnw = 1'b0; sel = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    #1 sel = 1'b0;
    lat = -1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (ack) lat = n;
    end
    rst_n = 1'b1;
    m_reset();
    checks++;
    if (lat !== -1) begin
      errs++;
      $display("FAIL rstmid_ack got lat=%0d exp=-1", lat);
    end
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (udo[32*i +: 32] !== RVAL) begin
        errs++;
        $display("FAIL rstmid_out[%0d] got=%h exp=%h",
                 i, udo[32*i +: 32], RVAL);
      end
    end
    xfer(1, BASE + 32'd4, 0, 4'b1111, rd, lat);
    checks++;
    if (rd !== RVAL) begin
      errs++;
      $display("FAIL rstmid_shadow got=%h exp=%h", rd, RVAL);
    end
    xfer(1, BASE + 32'(N*4), 0, 4'b1111, rd, lat);
    checks++;
    if (rd !== 32'h2) begin
      errs++;
      $display("FAIL rstmid_ctrl got=%h exp=%h", rd, 32'h2);
    end
  endtask

  initial begin
    abus = '0; dbus = '0; be = '0;
    rnw = 1'b1; sel = 1'b0; seq = 1'b0;
    m_reset();
    test_reset();
    test_auto_write();
    test_byte_enable();
    test_random_auto();
    test_manual();
    test_random_auto();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
